dlk_base_table: RTL and testbench

- Responder side of the data-leak tracking interface driven by the branch/ALU stage.
- The issuing stage sends two kinds of request:
  - store-byte events: base register value plus effective address;
  - load queries: base plus effective address.
- The table records, per base address, the highest byte address written (the high-water mark, hwm).
- For each load query it returns a registered overflow flag when the load reads beyond the bytes written through that base.

---
 rtl/dlk_base_table.sv | 205 ++++++++++++++++++++
 tb/tb_dlk_base_table.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dlk_base_table.sv
// dlk_base_table: per-base high-water-mark table for data-leak tracking.
// Store-byte events raise the highest written byte address of the entry
// for their base register. Load queries get a registered overflow flag
// when they read past the bytes written through the same base.
module dlk_base_table #(
    parameter int N_ENTRIES = 8,
    parameter int ADDR_W    = 32,
    parameter int MAX_SPAN  = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         rst_us_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    input  logic [ADDR_W-1:0]            wr_base_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic                         rd_valid_i,
    input  logic [ADDR_W-1:0]            rd_base_i,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    output logic                         rd_resp_valid_o,
    output logic                         rd_overflow_o,
    input  logic [$clog2(N_ENTRIES)-1:0] dbg_index_i,
    output logic [ADDR_W-1:0]            dbg_base_o,
    output logic [ADDR_W-1:0]            dbg_hwm_o,
    output logic [$clog2(N_ENTRIES):0]   count_o,
    output logic                         full_o
);

    localparam int IDX_W = $clog2(N_ENTRIES);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W:0]    SPAN     = (ADDR_W+1)'(MAX_SPAN);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(N_ENTRIES);
    localparam logic [CNT_W-1:0]   CNT_PRE  = CNT_W'(N_ENTRIES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_ENTRIES - 1);

    typedef enum logic {S_IDLE, S_UPDATE} state_t;

    state_t              r_state;
    state_t              w_stateNext;

    logic                r_valid [N_ENTRIES];
    logic [ADDR_W-1:0]   r_base  [N_ENTRIES];
    logic [ADDR_W-1:0]   r_hwm   [N_ENTRIES];
    logic [IDX_W-1:0]    r_head;
    logic [CNT_W-1:0]    r_count;
    logic                r_full;

    logic [ADDR_W-1:0]   r_wrBase;
    logic [ADDR_W-1:0]   r_wrAddr;
    logic                r_wrInSpan;
    logic                r_wrHit;
    logic [IDX_W-1:0]    r_wrHitIdx;

    logic                r_respValid;
    logic                r_overflow;

    logic                w_wrFire;
    logic                w_wrHit;
    logic [IDX_W-1:0]    w_wrHitIdx;
    logic                w_rdHit;
    logic [IDX_W-1:0]    w_rdHitIdx;
    logic                w_rdOverflow;

    // Range test in ADDR_W+1 bits so base+MAX_SPAN cannot wrap past zero.
    function automatic logic inSpan(input logic [ADDR_W-1:0] base,
                                    input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        logic [ADDR_W:0] a;
        lo = {1'b0, base};
        hi = lo + SPAN;
        a  = {1'b0, addr};
        return (a >= lo) && (a < hi);
    endfunction

    assign wr_ready_o      = (r_state == S_IDLE) && !rst_i;
    assign w_wrFire        = wr_valid_i && wr_ready_o;
    assign rd_resp_valid_o = r_respValid;
    assign rd_overflow_o   = r_overflow;
    assign count_o         = r_count;
    assign full_o          = r_full;

    // Look up the store's base among valid entries (bases are unique).
    always_comb begin
        w_wrHit    = 1'b0;
        w_wrHitIdx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (r_valid[i] && (r_base[i] == wr_base_i)) begin
                w_wrHit    = 1'b1;
                w_wrHitIdx = IDX_W'(i);
            end
        end
    end

    // Look up the load's base and decide whether it reads past the hwm.
    always_comb begin
        w_rdHit    = 1'b0;
        w_rdHitIdx = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (r_valid[i] && (r_base[i] == rd_base_i)) begin
                w_rdHit    = 1'b1;
                w_rdHitIdx = IDX_W'(i);
            end
        end
        w_rdOverflow = rd_valid_i && w_rdHit && inSpan(rd_base_i, rd_addr_i)
                       && (rd_addr_i > r_hwm[w_rdHitIdx]);
    end

    // Debug port: combinational read that shows zeros for invalid slots.
    always_comb begin
        dbg_base_o = '0;
        dbg_hwm_o  = '0;
        if (({1'b0, dbg_index_i} < CNT_MAX) && r_valid[dbg_index_i]) begin
            dbg_base_o = r_base[dbg_index_i];
            dbg_hwm_o  = r_hwm[dbg_index_i];
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: accept in IDLE, apply in UPDATE; user clear forces IDLE.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:   if (w_wrFire) w_stateNext = S_UPDATE;
            S_UPDATE: w_stateNext = S_IDLE;
            default:  w_stateNext = S_IDLE;
        endcase
        if (rst_us_i) begin
            w_stateNext = S_IDLE;
        end
    end

    // Capture the accepted store and its lookup results for the UPDATE cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wrBase   <= '0;
            r_wrAddr   <= '0;
            r_wrInSpan <= 1'b0;
            r_wrHit    <= 1'b0;
            r_wrHitIdx <= '0;
        end else if (w_wrFire) begin
            r_wrBase   <= wr_base_i;
            r_wrAddr   <= wr_addr_i;
            r_wrInSpan <= inSpan(wr_base_i, wr_addr_i);
            r_wrHit    <= w_wrHit;
            r_wrHitIdx <= w_wrHitIdx;
        end
    end

    // Table update: raise hwm on a hit, otherwise allocate or evict the oldest.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_base[i]  <= '0;
                r_hwm[i]   <= '0;
            end
            r_head  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (rst_us_i) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
            r_head  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if ((r_state == S_UPDATE) && r_wrInSpan) begin
            if (r_wrHit) begin
                if (r_wrAddr > r_hwm[r_wrHitIdx]) begin
                    r_hwm[r_wrHitIdx] <= r_wrAddr;
                end
            end else begin
                r_valid[r_head] <= 1'b1;
                r_base[r_head]  <= r_wrBase;
                r_hwm[r_head]   <= r_wrAddr;
                r_head          <= (r_head == IDX_LAST) ? '0 : r_head + 1'b1;
                if (r_count != CNT_MAX) begin
                    r_count <= r_count + 1'b1;
                    r_full  <= (r_count == CNT_PRE);
                end
            end
        end
    end

    // Query response registered one cycle after the request, pre-update table.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_respValid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_respValid <= rd_valid_i;
            r_overflow  <= w_rdOverflow;
        end
    end

endmodule

// File: tb/tb_dlk_base_table.sv
// tb_dlk_base_table: directed bench for dlk_base_table. Expected query
// results are queued when a load is issued and compared when the
// response comes back; table state is checked through count/full/dbg.
module tb_dlk_base_table;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        rst_us_i = 1'b0;
    logic        wr_valid_i = 1'b0;
    logic        wr_ready_o;
    logic [31:0] wr_base_i = '0;
    logic [31:0] wr_addr_i = '0;
    logic        rd_valid_i = 1'b0;
    logic [31:0] rd_base_i = '0;
    logic [31:0] rd_addr_i = '0;
    logic        rd_resp_valid_o;
    logic        rd_overflow_o;
    logic [2:0]  dbg_index_i = '0;
    logic [31:0] dbg_base_o;
    logic [31:0] dbg_hwm_o;
    logic [3:0]  count_o;
    logic        full_o;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic        expQ[$];

    dlk_base_table #(.N_ENTRIES(8), .ADDR_W(32), .MAX_SPAN(256)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .rst_us_i        (rst_us_i),
        .wr_valid_i      (wr_valid_i),
        .wr_ready_o      (wr_ready_o),
        .wr_base_i       (wr_base_i),
        .wr_addr_i       (wr_addr_i),
        .rd_valid_i      (rd_valid_i),
        .rd_base_i       (rd_base_i),
        .rd_addr_i       (rd_addr_i),
        .rd_resp_valid_o (rd_resp_valid_o),
        .rd_overflow_o   (rd_overflow_o),
        .dbg_index_i     (dbg_index_i),
        .dbg_base_o      (dbg_base_o),
        .dbg_hwm_o       (dbg_hwm_o),
        .count_o         (count_o),
        .full_o          (full_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk_i = ~clk_i;

    // Hard stop in case a wait never completes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards check the response of any load issued before it.
    task automatic tick();
        logic wasQuery;
        logic e;
        wasQuery = rd_valid_i;
        @(posedge clk_i);
        #1;
        checkOutput("respValid", rd_resp_valid_o, wasQuery);
        if (wasQuery) begin
            if (expQ.size() == 0) begin
                checkOutput("scoreboardUnderflow", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("overflow", rd_overflow_o, e);
            end
        end else begin
            checkOutput("overflowIdle", rd_overflow_o, 1'b0);
        end
    endtask

    // Issue one load query for one cycle with its expected overflow flag.
    task automatic applyQuery(input logic [31:0] base, input logic [31:0] addr,
                              input logic exp);
        rd_valid_i = 1'b1;
        rd_base_i  = base;
        rd_addr_i  = addr;
        expQ.push_back(exp);
        tick();
        rd_valid_i = 1'b0;
    endtask

    // One complete store event: handshake cycle plus UPDATE cycle.
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] addr);
        int n;
        n = 0;
        while (!wr_ready_o && n < 10) begin
            tick();
            n++;
        end
        if (!wr_ready_o) checkOutput("readyTimeout", wr_ready_o, 1'b1);
        wr_valid_i = 1'b1;
        wr_base_i  = base;
        wr_addr_i  = addr;
        tick();
        wr_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        // Asynchronous reset and its output values.
        #1 rst_i = 1'b1;
        #1;
        checkOutput("rstReady", wr_ready_o, 1'b0);
        checkOutput("rstCount", count_o, 4'd0);
        checkOutput("rstFull", full_o, 1'b0);
        checkOutput("rstResp", rd_resp_valid_o, 1'b0);
        checkOutput("rstOvf", rd_overflow_o, 1'b0);
        checkOutput("rstDbgBase", dbg_base_o, 32'd0);
        checkOutput("rstDbgHwm", dbg_hwm_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        checkOutput("readyAfterRst", wr_ready_o, 1'b1);
        checkOutput("countAfterRst", count_o, 4'd0);

        // Four byte stores through one base, then load checks around the hwm.
        for (int i = 0; i < 4; i++) applyStimulus(32'h8000_1000, 32'h8000_1000 + i);
        dbg_index_i = 3'd0;
        #1;
        checkOutput("count1", count_o, 4'd1);
        checkOutput("dbgBase0", dbg_base_o, 32'h8000_1000);
        checkOutput("dbgHwm0", dbg_hwm_o, 32'h8000_1003);
        applyQuery(32'h8000_1000, 32'h8000_1003, 1'b0);
        applyQuery(32'h8000_1000, 32'h8000_1004, 1'b1);
        applyQuery(32'h8000_1000, 32'h8000_1100, 1'b0);
        applyQuery(32'h8000_1000, 32'h8000_0FFF, 1'b0);

        // wr_valid_i held for 6 cycles: only every other cycle is accepted.
        for (int i = 0; i < 6; i++) begin
            wr_valid_i = 1'b1;
            wr_base_i  = 32'h8000_2000;
            wr_addr_i  = 32'h8000_2000 + i;
            checkOutput("readyToggle", wr_ready_o, (i % 2) == 0);
            tick();
        end
        wr_valid_i = 1'b0;
        dbg_index_i = 3'd1;
        #1;
        checkOutput("count2", count_o, 4'd2);
        checkOutput("dbgBase1", dbg_base_o, 32'h8000_2000);
        checkOutput("dbgHwm1", dbg_hwm_o, 32'h8000_2004);

        // Store at base+MAX_SPAN is dropped; unknown base never overflows.
        applyStimulus(32'h8000_1000, 32'h8000_1100);
        dbg_index_i = 3'd0;
        #1;
        checkOutput("dropCount", count_o, 4'd2);
        checkOutput("dropHwm", dbg_hwm_o, 32'h8000_1003);
        applyQuery(32'h9000_0000, 32'h9000_0010, 1'b0);

        // User clear with the FSM idle empties the table.
        rst_us_i = 1'b1;
        tick();
        rst_us_i = 1'b0;
        checkOutput("usClearCount", count_o, 4'd0);
        checkOutput("usClearDbg", dbg_base_o, 32'd0);

        // Fill all 8 slots, then a 9th base evicts slot 0.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(32'hA000_0000 + k * 32'h1000, 32'hA000_0010 + k * 32'h1000);
            if (k == 6) begin
                checkOutput("count7", count_o, 4'd7);
                checkOutput("notFull7", full_o, 1'b0);
            end
            if (k == 7) begin
                checkOutput("count8", count_o, 4'd8);
                checkOutput("full8", full_o, 1'b1);
            end
        end
        dbg_index_i = 3'd0;
        #1;
        checkOutput("evictCount", count_o, 4'd8);
        checkOutput("evictFull", full_o, 1'b1);
        checkOutput("evictBase", dbg_base_o, 32'hA000_8000);
        checkOutput("evictHwm", dbg_hwm_o, 32'hA000_8010);
        applyQuery(32'hA000_0000, 32'hA000_0020, 1'b0);
        applyQuery(32'hA000_1000, 32'hA000_1020, 1'b1);
        applyQuery(32'hA000_8000, 32'hA000_8011, 1'b1);
        applyQuery(32'hA000_8000, 32'hA000_8010, 1'b0);

        // User clear during UPDATE aborts the write; query sees old table.
        wr_valid_i = 1'b1;
        wr_base_i  = 32'hC000_0000;
        wr_addr_i  = 32'hC000_0004;
        tick();
        wr_valid_i = 1'b0;
        rst_us_i   = 1'b1;
        applyQuery(32'hA000_1000, 32'hA000_1020, 1'b1);
        rst_us_i   = 1'b0;
        checkOutput("abortCount", count_o, 4'd0);
        checkOutput("abortFull", full_o, 1'b0);
        checkOutput("abortReady", wr_ready_o, 1'b1);
        tick();
        dbg_index_i = 3'd1;
        #1;
        checkOutput("abortNoWrite", count_o, 4'd0);
        checkOutput("abortDbg", dbg_base_o, 32'd0);

        // Async reset mid-UPDATE clears everything without a clock edge.
        applyStimulus(32'hD000_0000, 32'hD000_0005);
        checkOutput("preRstCount", count_o, 4'd1);
        wr_valid_i = 1'b1;
        wr_base_i  = 32'hD000_1000;
        wr_addr_i  = 32'hD000_1000;
        applyQuery(32'hD000_0000, 32'hD000_0006, 1'b1);
        wr_valid_i = 1'b0;
        checkOutput("inUpdateReady", wr_ready_o, 1'b0);
        dbg_index_i = 3'd0;
        #2 rst_i = 1'b1;
        #1;
        checkOutput("asyncReady", wr_ready_o, 1'b0);
        checkOutput("asyncCount", count_o, 4'd0);
        checkOutput("asyncFull", full_o, 1'b0);
        checkOutput("asyncResp", rd_resp_valid_o, 1'b0);
        checkOutput("asyncOvf", rd_overflow_o, 1'b0);
        checkOutput("asyncDbgBase", dbg_base_o, 32'd0);
        checkOutput("asyncDbgHwm", dbg_hwm_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        checkOutput("readyAfterAsync", wr_ready_o, 1'b1);
        checkOutput("countAfterAsync", count_o, 4'd0);

        checkOutput("queueEmpty", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
